// File: rtl/ah_demux_sched.sv
// ============================================================================
// Module   : ah_demux_sched
// Purpose  : Per-packet select scheduler for the AH valid/ready egress demux.
//            Optional stall watchdog enabled by macro AH_DEMUX_SCHED_WDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ah_demux_sched #(
    parameter int NUM_EGR = 24,
    parameter int SEL_W   = 5,
    parameter int CNT_W   = 16,
    parameter int TO_CYC  = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] dst_data,
    input  logic             dst_valid,
    output logic             dst_ready,
    input  logic             ing_valid,
    input  logic             ing_last,
    output logic             ing_ready,
    output logic             dmx_valid,
    input  logic             dmx_ready,
    output logic [SEL_W-1:0] dmx_select,
    output logic             busy,
    output logic             err_bad_dst,
    output logic             err_timeout,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam logic [SEL_W:0]   c_NUM_EGR = (SEL_W+1)'(NUM_EGR);
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    if ((2**SEL_W < NUM_EGR) || (TO_CYC < 1) || (TO_CYC > 255)) begin : g_param_err
        $error("ah_demux_sched: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUTE = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_accept_ok;
    logic             w_accept_bad;
    logic             w_pkt_done;
    logic             w_drop_done;
    logic             w_wdog_fire;
    logic [SEL_W-1:0] r_select;
    logic [CNT_W-1:0] r_pkt_cnt;
    logic [CNT_W-1:0] r_drop_cnt;
    logic             r_err_bad_dst;
    logic             r_err_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        dst_ready    = 1'b0;
        ing_ready    = 1'b0;
        dmx_valid    = 1'b0;
        w_accept_ok  = 1'b0;
        w_accept_bad = 1'b0;
        w_pkt_done   = 1'b0;
        w_drop_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                dst_ready = 1'b1;
                if (dst_valid) begin
                    if ({1'b0, dst_data} < c_NUM_EGR) begin
                        w_accept_ok = 1'b1;
                        w_next      = S_ROUTE;
                    end else begin
                        w_accept_bad = 1'b1;
                        w_next       = S_DROP;
                    end
                end
            end
            S_ROUTE: begin
                dmx_valid = ing_valid;
                ing_ready = dmx_ready;
                if (ing_valid && dmx_ready && ing_last) begin
                    w_pkt_done = 1'b1;
                    w_next     = S_IDLE;
                end else if (w_wdog_fire) begin
                    w_next = S_DROP;
                end
            end
            S_DROP: begin
                ing_ready = 1'b1;
                if (ing_valid && ing_last) begin
                    w_drop_done = 1'b1;
                    w_next      = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

`ifdef AH_DEMUX_SCHED_WDOG_EN
    localparam logic [7:0] c_TO_LAST = 8'(TO_CYC - 1);

    logic [7:0] r_stall;
    logic       w_stall;

    assign w_stall     = (r_state == S_ROUTE) && ing_valid && !dmx_ready;
    // Fires on the stall cycle that brings the count up to TO_CYC.
    assign w_wdog_fire = w_stall && (r_stall == c_TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= 8'd0;
        end else if ((r_state != S_ROUTE) || (w_next != S_ROUTE) || (ing_valid && dmx_ready)) begin
            r_stall <= 8'd0;
        end else if (w_stall) begin
            r_stall <= r_stall + 8'd1;
        end
    end
`else
    assign w_wdog_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_select      <= '0;
            r_pkt_cnt     <= '0;
            r_drop_cnt    <= '0;
            r_err_bad_dst <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_err_bad_dst <= w_accept_bad;
            r_err_timeout <= w_wdog_fire;
            if (w_accept_ok) begin
                r_select <= dst_data;
            end
            if (w_pkt_done) begin
                r_pkt_cnt <= r_pkt_cnt + c_CNT_ONE;
            end
            if (w_drop_done) begin
                r_drop_cnt <= r_drop_cnt + c_CNT_ONE;
            end
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign dmx_select  = r_select;
    assign pkt_cnt     = r_pkt_cnt;
    assign drop_cnt    = r_drop_cnt;
    assign err_bad_dst = r_err_bad_dst;
    assign err_timeout = r_err_timeout;

endmodule

`default_nettype wire

// File: tb/tb_ah_demux_sched.sv
// ============================================================================
// Module   : tb_ah_demux_sched
// Purpose  : Self-checking bench for ah_demux_sched (vector table, directed
//            corner sequences, randomized traffic against a packet-level model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ah_demux_sched;

    localparam int c_TO = 16;
`ifdef AH_DEMUX_SCHED_WDOG_EN
    localparam bit c_WD = 1'b1;
`else
    localparam bit c_WD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] dst_data;
    logic       dst_valid;
    logic       dst_ready;
    logic       ing_valid;
    logic       ing_last;
    logic       ing_ready;
    logic       dmx_valid;
    logic       dmx_ready;
    logic [4:0] dmx_select;
    logic       busy;
    logic       err_bad_dst;
    logic       err_timeout;
    logic [15:0] pkt_cnt;
    logic [15:0] drop_cnt;

    ah_demux_sched #(.NUM_EGR(24), .SEL_W(5), .CNT_W(16), .TO_CYC(c_TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .dst_data(dst_data), .dst_valid(dst_valid), .dst_ready(dst_ready),
        .ing_valid(ing_valid), .ing_last(ing_last), .ing_ready(ing_ready),
        .dmx_valid(dmx_valid), .dmx_ready(dmx_ready), .dmx_select(dmx_select),
        .busy(busy), .err_bad_dst(err_bad_dst), .err_timeout(err_timeout),
        .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_tot = 0;
    int n_bad = 0;
    int g_xfer = 0;
    int g_to_seen = 0;
    int g_bad_seen = 0;

    // Packet-level reference: whether a packet is open, whether it is being
    // discarded, which port it is routed to, and running totals.
    bit m_open, m_discard, m_bad, m_to;
    int m_port, m_pkts, m_drops, m_wait;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_open = 0; m_discard = 0; m_bad = 0; m_to = 0;
        m_port = 0; m_pkts = 0; m_drops = 0; m_wait = 0;
    endtask

    task automatic model_step();
        bit nb = 0;
        bit nt = 0;
        if (!m_open) begin
            if (dst_valid) begin
                m_open = 1; m_wait = 0;
                if (int'(dst_data) < 24) begin
                    m_port = int'(dst_data); m_discard = 0;
                end else begin
                    m_discard = 1; nb = 1;
                end
            end
        end else if (!m_discard) begin
            if (ing_valid && dmx_ready) begin
                m_wait = 0;
                if (ing_last) begin
                    m_pkts = (m_pkts + 1) % 65536; m_open = 0;
                end
            end else if (ing_valid) begin
                m_wait++;
                if (c_WD && m_wait >= c_TO) begin
                    nt = 1; m_discard = 1; m_wait = 0;
                end
            end
        end else if (ing_valid && ing_last) begin
            m_drops = (m_drops + 1) % 65536; m_open = 0;
        end
        m_bad = nb; m_to = nt;
    endtask

    task automatic check_model();
        chk("dst_ready",   32'(dst_ready),   32'(!m_open));
        chk("ing_ready",   32'(ing_ready),   32'(m_open && (m_discard || dmx_ready)));
        chk("dmx_valid",   32'(dmx_valid),   32'(m_open && !m_discard && ing_valid));
        chk("dmx_select",  32'(dmx_select),  32'(m_port));
        chk("busy",        32'(busy),        32'(m_open));
        chk("pkt_cnt",     32'(pkt_cnt),     32'(m_pkts));
        chk("drop_cnt",    32'(drop_cnt),    32'(m_drops));
        chk("err_bad_dst", 32'(err_bad_dst), 32'(m_bad));
        chk("err_timeout", 32'(err_timeout), 32'(m_to));
        if (dmx_valid && dmx_ready && ing_ready) g_xfer++;
        if (err_timeout) g_to_seen++;
        if (err_bad_dst) g_bad_seen++;
    endtask

    task automatic drive(input bit dv, input int dd, input bit iv, input bit il, input bit rdy);
        @(negedge clk);
        dst_valid = dv; dst_data = dd[4:0];
        ing_valid = iv; ing_last = il; dmx_ready = rdy;
        #1;
    endtask

    task automatic cycle(input bit dv, input int dd, input bit iv, input bit il, input bit rdy);
        drive(dv, dd, iv, il, rdy);
        check_model();
        @(posedge clk);
        model_step();
    endtask

    typedef struct {
        bit dv; int dd; bit iv; bit il; bit rdy;
        bit e_dr; bit e_ir; bit e_mv; int e_sel; bit e_busy; int e_pkt; int e_drop; bit e_bad;
    } vec_t;

    vec_t vt[15];

    initial begin
        int x0, b0, d0, p0;
        // inputs: dv dd iv il rdy | expected: dst_ready ing_ready dmx_valid sel busy pkt drop bad
        vt[0]  = '{1, 3,  0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{0, 0,  1, 0, 1,  0, 1, 1, 3, 1, 0, 0, 0};
        vt[2]  = '{0, 0,  1, 0, 1,  0, 1, 1, 3, 1, 0, 0, 0};
        vt[3]  = '{0, 0,  1, 0, 1,  0, 1, 1, 3, 1, 0, 0, 0};
        vt[4]  = '{0, 0,  1, 1, 1,  0, 1, 1, 3, 1, 0, 0, 0};
        vt[5]  = '{0, 0,  0, 0, 1,  1, 0, 0, 3, 0, 1, 0, 0};
        vt[6]  = '{1, 30, 0, 0, 1,  1, 0, 0, 3, 0, 1, 0, 0};
        vt[7]  = '{0, 0,  1, 0, 0,  0, 1, 0, 3, 1, 1, 0, 1};
        vt[8]  = '{0, 0,  1, 0, 1,  0, 1, 0, 3, 1, 1, 0, 0};
        vt[9]  = '{0, 0,  1, 1, 1,  0, 1, 0, 3, 1, 1, 0, 0};
        vt[10] = '{1, 5,  1, 1, 1,  1, 0, 0, 3, 0, 1, 1, 0};
        vt[11] = '{1, 7,  1, 1, 1,  0, 1, 1, 5, 1, 1, 1, 0};
        vt[12] = '{1, 7,  1, 1, 1,  1, 0, 0, 5, 0, 2, 1, 0};
        vt[13] = '{0, 0,  1, 1, 1,  0, 1, 1, 7, 1, 2, 1, 0};
        vt[14] = '{0, 0,  0, 0, 1,  1, 0, 0, 7, 0, 3, 1, 0};

        rst_n = 1'b0; dst_valid = 0; dst_data = 0; ing_valid = 0; ing_last = 0; dmx_ready = 0;
        model_reset();
        @(negedge clk); @(negedge clk); #1;
        chk("rst_dst_ready", 32'(dst_ready), 1);
        chk("rst_ing_ready", 32'(ing_ready), 0);
        chk("rst_dmx_valid", 32'(dmx_valid), 0);
        chk("rst_select",    32'(dmx_select), 0);
        chk("rst_busy",      32'(busy), 0);
        chk("rst_pkt_cnt",   32'(pkt_cnt), 0);
        chk("rst_drop_cnt",  32'(drop_cnt), 0);
        chk("rst_errs",      32'({err_bad_dst, err_timeout}), 0);
        @(negedge clk); rst_n = 1'b1;

        // Directed table: routed packet, illegal destination, back-to-back singles.
        for (int i = 0; i < 15; i++) begin
            drive(vt[i].dv, vt[i].dd, vt[i].iv, vt[i].il, vt[i].rdy);
            chk($sformatf("vec%0d_dst_ready", i), 32'(dst_ready), 32'(vt[i].e_dr));
            chk($sformatf("vec%0d_ing_ready", i), 32'(ing_ready), 32'(vt[i].e_ir));
            chk($sformatf("vec%0d_dmx_valid", i), 32'(dmx_valid), 32'(vt[i].e_mv));
            chk($sformatf("vec%0d_select", i),    32'(dmx_select), 32'(vt[i].e_sel));
            chk($sformatf("vec%0d_busy", i),      32'(busy), 32'(vt[i].e_busy));
            chk($sformatf("vec%0d_pkt_cnt", i),   32'(pkt_cnt), 32'(vt[i].e_pkt));
            chk($sformatf("vec%0d_drop_cnt", i),  32'(drop_cnt), 32'(vt[i].e_drop));
            chk($sformatf("vec%0d_bad_dst", i),   32'(err_bad_dst), 32'(vt[i].e_bad));
            chk($sformatf("vec%0d_timeout", i),   32'(err_timeout), 0);
            @(posedge clk);
            model_step();
        end

        // Long egress stall on port 2: nothing lost, nothing duplicated.
        x0 = g_xfer; p0 = m_pkts;
        cycle(1, 2, 0, 0, 1);
        for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 1);
        cycle(0, 0, 1, 0, 1);
        cycle(0, 0, 1, 1, 1);
        cycle(0, 0, 0, 0, 1);
        chk("stall_beats", 32'(g_xfer - x0), 3);
        chk("stall_pkt_cnt", 32'(pkt_cnt), 32'(p0 + 1));
        chk("stall_select", 32'(dmx_select), 2);

        // Reset in the middle of a routed packet.
        cycle(1, 9, 0, 0, 1);
        cycle(0, 0, 1, 0, 1);
        @(negedge clk);
        rst_n = 1'b0; ing_valid = 1; dmx_ready = 1;
        #1;
        chk("midrst_dmx_valid", 32'(dmx_valid), 0);
        chk("midrst_select",    32'(dmx_select), 0);
        chk("midrst_pkt_cnt",   32'(pkt_cnt), 0);
        chk("midrst_drop_cnt",  32'(drop_cnt), 0);
        chk("midrst_busy",      32'(busy), 0);
        chk("midrst_dst_ready", 32'(dst_ready), 1);
        model_reset();
        @(negedge clk); rst_n = 1'b1; ing_valid = 0;

`ifdef AH_DEMUX_SCHED_WDOG_EN
        // Watchdog: stall long enough to trip, then the remainder is flushed.
        x0 = g_to_seen; d0 = m_drops; p0 = m_pkts;
        cycle(1, 4, 0, 0, 0);
        for (int i = 0; i < c_TO; i++) cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 0, 0, 1);
        chk("wdog_pulses",   32'(g_to_seen - x0), 1);
        chk("wdog_drop_cnt", 32'(drop_cnt), 32'(d0 + 1));
        chk("wdog_pkt_cnt",  32'(pkt_cnt), 32'(p0));
`endif

        // Randomized traffic against the reference model.
        b0 = g_bad_seen;
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 31),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) != 0);
        end
        if (g_bad_seen == b0) begin
            n_tot++; n_bad++;
            $display("FAIL rand_bad_dst_coverage: got 0 pulses expected >0");
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
